// File: rtl/uart_tx_sequencer.sv
// Bus master that programs the uart prescaler and enable, then drains a byte FIFO into tx_data,
// polling the status register before every byte. Optional bus timeout: UART_TX_SEQ_BUS_TIMEOUT_EN.
module uart_tx_sequencer #(
    parameter int         FIFO_DEPTH     = 8,
    parameter logic [4:0] STATUS_OFFSET  = 5'h08,
    parameter int         TX_BUSY_BIT    = 0,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [31:0] i_cfg_prescaler,
    input  logic        i_in_valid,
    input  logic [7:0]  i_in_data,
    output logic        o_in_ready,
    output logic        o_select,
    output logic [3:0]  o_wstrb,
    output logic [4:0]  o_addr,
    output logic [31:0] o_data_o,
    input  logic        i_ready,
    input  logic [31:0] i_data_i,
    output logic        o_cfg_done,
    output logic        o_busy,
    output logic        o_err
);
    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE    = 1;
    localparam logic [4:0]  ADDR_CTRL  = 5'h00;
    localparam logic [4:0]  ADDR_PRESC = 5'h04;
    localparam logic [4:0]  ADDR_TX    = 5'h10;
    localparam logic [3:0]  WSTRB_WR   = 4'b1111;
    localparam logic [3:0]  WSTRB_RD   = 4'b0000;
    localparam logic [31:0] EN_WORD    = 32'h2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG_PRESC,
        S_CFG_EN,
        S_DRAIN_WAIT,
        S_POLL,
        S_WRITE_TX,
        S_GAP
    } state_t;

    state_t      r_state, w_state_nxt;
    state_t      r_gap_next, w_gap_nxt;
    logic        r_select, w_select_nxt;
    logic [3:0]  r_wstrb, w_wstrb_nxt;
    logic [4:0]  r_addr, w_addr_nxt;
    logic [31:0] r_data, w_data_nxt;
    logic        r_cfg_done, w_cfg_done_nxt;

    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic        w_full, w_empty, w_push, w_pop;
    logic        w_done, w_timeout, w_tx_busy;
    logic [7:0]  w_head;
    logic        w_unused_data;

    // ------------------------------------------------------------------
    // Byte FIFO: wrap bit distinguishes full from empty
    // ------------------------------------------------------------------
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push     = i_in_valid && !w_full;
    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
    assign o_in_ready = !w_full;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_in_data;
    end

    // ready only means something while a transaction is outstanding
    assign w_done        = r_select && i_ready;
    assign w_tx_busy     = i_data_i[TX_BUSY_BIT];
    assign w_unused_data = ^i_data_i;

    // ------------------------------------------------------------------
    // Optional bus watchdog
    // ------------------------------------------------------------------
`ifdef UART_TX_SEQ_BUS_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_ONE  = 1;

    logic [TW-1:0] r_to_cnt;
    logic          r_err;

    always_ff @(posedge i_clk) begin
        if (i_reset || !r_select) r_to_cnt <= '0;
        else                      r_to_cnt <= r_to_cnt + TO_ONE;
    end

    assign w_timeout = r_select && !i_ready && (r_to_cnt == TO_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset)        r_err <= 1'b0;
        else if (w_timeout) r_err <= 1'b1;
    end

    assign o_err = r_err;
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
    assign o_err            = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencer FSM: bus fields are loaded on entry to a bus state so
    // select rises on the same edge the state changes
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_gap_next <= S_IDLE;
            r_select   <= 1'b0;
            r_wstrb    <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_cfg_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gap_next <= w_gap_nxt;
            r_select   <= w_select_nxt;
            r_wstrb    <= w_wstrb_nxt;
            r_addr     <= w_addr_nxt;
            r_data     <= w_data_nxt;
            r_cfg_done <= w_cfg_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gap_nxt      = r_gap_next;
        w_select_nxt   = r_select;
        w_wstrb_nxt    = r_wstrb;
        w_addr_nxt     = r_addr;
        w_data_nxt     = r_data;
        w_cfg_done_nxt = r_cfg_done;
        w_pop          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt  = S_CFG_PRESC;
                    w_select_nxt = 1'b1;
                    w_wstrb_nxt  = WSTRB_WR;
                    w_addr_nxt   = ADDR_PRESC;
                    w_data_nxt   = i_cfg_prescaler;
                end
            end
            S_CFG_PRESC: begin
                if (w_done) begin
                    w_select_nxt = 1'b0;
                    w_state_nxt  = S_GAP;
                    w_gap_nxt    = S_CFG_EN;
                end
            end
            S_CFG_EN: begin
                if (w_done) begin
                    w_select_nxt   = 1'b0;
                    w_cfg_done_nxt = 1'b1;
                    w_state_nxt    = S_DRAIN_WAIT;
                end
            end
            S_DRAIN_WAIT: begin
                if (!w_empty) begin
                    w_state_nxt  = S_POLL;
                    w_select_nxt = 1'b1;
                    w_wstrb_nxt  = WSTRB_RD;
                    w_addr_nxt   = STATUS_OFFSET;
                    w_data_nxt   = '0;
                end
            end
            S_POLL: begin
                if (w_done) begin
                    w_select_nxt = 1'b0;
                    w_state_nxt  = S_GAP;
                    w_gap_nxt    = w_tx_busy ? S_POLL : S_WRITE_TX;
                end
            end
            S_WRITE_TX: begin
                if (w_done) begin
                    w_select_nxt = 1'b0;
                    w_pop        = 1'b1;
                    w_state_nxt  = S_GAP;
                    w_gap_nxt    = S_DRAIN_WAIT;
                end
            end
            S_GAP: begin
                w_state_nxt = r_gap_next;
                case (r_gap_next)
                    S_CFG_EN: begin
                        w_select_nxt = 1'b1;
                        w_wstrb_nxt  = WSTRB_WR;
                        w_addr_nxt   = ADDR_CTRL;
                        w_data_nxt   = EN_WORD;
                    end
                    S_POLL: begin
                        w_select_nxt = 1'b1;
                        w_wstrb_nxt  = WSTRB_RD;
                        w_addr_nxt   = STATUS_OFFSET;
                        w_data_nxt   = '0;
                    end
                    S_WRITE_TX: begin
                        w_select_nxt = 1'b1;
                        w_wstrb_nxt  = WSTRB_WR;
                        w_addr_nxt   = ADDR_TX;
                        w_data_nxt   = {24'd0, w_head};
                    end
                    default: ;
                endcase
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // an abandoned transaction leaves the uart unconfigured as far as we know
        if (w_timeout) begin
            w_select_nxt   = 1'b0;
            w_state_nxt    = S_IDLE;
            w_cfg_done_nxt = 1'b0;
        end
    end

    assign o_select   = r_select;
    assign o_wstrb    = r_wstrb;
    assign o_addr     = r_addr;
    assign o_data_o   = r_data;
    assign o_cfg_done = r_cfg_done;
    assign o_busy     = (r_state != S_IDLE) && (r_state != S_DRAIN_WAIT);

endmodule
